pll_reset_sequencer: RTL and testbench

- Sits directly downstream of the board PLL wrapper.
- Consumes the PLL's asynchronous `locked` output and generates a clean, glitch-free, synchronously deasserted active-high reset for logic in one PLL output clock domain.
- Requires lock to be stable for a qualification window, then holds reset for a fixed count before release.
- Re-sequences on lock loss or on a soft reset request, and counts lock-loss events for debug LEDs/UART.

---
 rtl/pll_reset_sequencer.sv | 97 +++++++++
 tb/tb_pll_reset_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualifier and synchronous reset sequencer
// Turns an asynchronous PLL lock flag into a clean, synchronously released domain reset.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int LOSS_W      = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              soft_rst,
    output logic              rst_out,
    output logic              ready,
    output logic              lock_lost,
    output logic [LOSS_W-1:0] loss_count
);

    localparam int MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK,
        S_STABILIZE,
        S_HOLD,
        S_RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_lock_s;
    logic                   w_loss;

    // The only place pll_locked is sampled; everything else sees w_lock_s.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];
    assign w_loss   = (r_state == S_RUN) && !w_lock_s;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT_LOCK: if (w_lock_s) w_next_state = S_STABILIZE;
            S_STABILIZE: begin
                if (!w_lock_s)               w_next_state = S_WAIT_LOCK;
                else if (r_cnt == LOCK_LAST) w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (!w_lock_s)               w_next_state = S_WAIT_LOCK;
                else if (r_cnt == HOLD_LAST) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (!w_lock_s)     w_next_state = S_WAIT_LOCK;
                else if (soft_rst) w_next_state = S_HOLD;
            end
            default: w_next_state = S_WAIT_LOCK;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_WAIT_LOCK;
            r_cnt      <= '0;
            rst_out    <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_STABILIZE || r_state == S_HOLD) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            rst_out <= (w_next_state != S_RUN);
            ready   <= (w_next_state == S_RUN);
            if (w_loss) begin
                lock_lost <= 1'b1;
                if (loss_count != '1) begin
                    loss_count <= loss_count + LOSS_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed vector bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst   = 1'b0;
    logic       rst_out;
    logic       ready;
    logic       lock_lost;
    logic [1:0] loss_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       pl;
        logic       sr;
        logic       rst;
        logic       rdy;
        logic       ll;
        logic [1:0] lc;
    } vec_t;

    vec_t vecs[$];

    pll_reset_sequencer #(
        .SYNC_STAGES(2),
        .LOCK_CYCLES(4),
        .HOLD_CYCLES(3),
        .LOSS_W     (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .rst_out    (rst_out),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .loss_count (loss_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int idx, input logic [4:0] exp);
        logic [4:0] act;
        act = {rst_out, ready, lock_lost, loss_count};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: rst/rdy/ll/lc got %b required %b", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic pl, input logic sr);
        @(negedge clock);
        pll_locked = pl;
        soft_rst   = sr;
        @(posedge clock);
        #1;
    endtask

    task automatic add(input int n, input logic pl, input logic sr, input logic rst,
                       input logic rdy, input logic ll, input logic [1:0] lc);
        vec_t v;
        v.pl = pl; v.sr = sr; v.rst = rst; v.rdy = rdy; v.ll = ll; v.lc = lc;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] sat_lc[3];
        sat_lc[0] = 2'd3; sat_lc[1] = 2'd3; sat_lc[2] = 2'd3;

        // First lock with a 2-cycle drop after e4; re-rise sampled at table index 7
        add(5, 1, 0, 1, 0, 0, 2'd0);
        add(2, 0, 0, 1, 0, 0, 2'd0);
        add(9, 1, 0, 1, 0, 0, 2'd0);
        add(3, 1, 0, 0, 1, 0, 2'd0);
        // Lock lost in RUN for 5 cycles, then relock
        add(2, 0, 0, 0, 1, 0, 2'd0);
        add(3, 0, 0, 1, 0, 1, 2'd1);
        add(9, 1, 0, 1, 0, 1, 2'd1);
        add(2, 1, 0, 0, 1, 1, 2'd1);
        // One-cycle soft reset in RUN
        add(1, 1, 1, 1, 0, 1, 2'd1);
        add(2, 1, 0, 1, 0, 1, 2'd1);
        add(2, 1, 0, 0, 1, 1, 2'd1);

        repeat (3) @(posedge clock);
        #1;
        check("reset_state", 0, 5'b1_0_0_00);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].pl, vecs[i].sr);
            check("table", i, {vecs[i].rst, vecs[i].rdy, vecs[i].ll, vecs[i].lc});
        end

        // Lock loss and soft_rst seen together: loss wins
        step(0, 0); check("simul_pre", 0, 5'b0_1_1_01);
        step(0, 0); check("simul_pre", 1, 5'b0_1_1_01);
        step(0, 1); check("simul_hit", 0, 5'b1_0_1_10);
        step(0, 0); check("simul_post", 0, 5'b1_0_1_10);

        // Three more losses from RUN: counter saturates
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) step(1, 0);
            check("sat_run", k, {3'b0_1_1, (k == 0) ? 2'd2 : 2'd3});
            for (int i = 0; i < 3; i++) step(0, 0);
            check("sat_loss", k, {3'b1_0_1, sat_lc[k]});
        end

        // Reset asserted mid-HOLD, checked with no clock edge in between
        for (int i = 0; i < 8; i++) step(1, 0);
        check("mid_hold", 0, 5'b1_0_1_11);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 0, 5'b1_0_0_00);

        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("restart", i, (i < 9) ? 5'b1_0_0_00 : 5'b0_1_0_00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
